// File: rtl/issue_queue_mw.sv
// Age-ordered compacting issue queue: holds renamed instructions until both sources
// are ready, issues the oldest ready entry, and accepts NUM_WAKEUP tag broadcasts per cycle.
module issue_queue_mw #(
  parameter  int NUM_PHYS_REGS = 64,
  parameter  int QUEUE_SIZE    = 16,
  parameter  int NUM_WAKEUP    = 2,
  parameter  int PAYLOAD_BITS  = 128,
  localparam int LOG_PHYS      = $clog2(NUM_PHYS_REGS),
  localparam int CNT_W         = $clog2(QUEUE_SIZE) + 1
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           Flush_IN,
  input  logic                           Enq_Valid_IN,
  output logic                           Enq_Ready_OUT,
  input  logic [LOG_PHYS-1:0]            Enq_Src1_IN,
  input  logic                           Enq_Src1Ready_IN,
  input  logic [LOG_PHYS-1:0]            Enq_Src2_IN,
  input  logic                           Enq_Src2Ready_IN,
  input  logic [PAYLOAD_BITS-1:0]        Enq_Payload_IN,
  input  logic [NUM_WAKEUP-1:0]          Wakeup_Valid_IN,
  input  logic [NUM_WAKEUP*LOG_PHYS-1:0] Wakeup_Reg_IN,
  output logic                           Issue_Valid_OUT,
  input  logic                           Issue_Ready_IN,
  output logic [PAYLOAD_BITS-1:0]        Issue_Payload_OUT,
  output logic [CNT_W-1:0]               Count_OUT
);

  localparam int IDX_W = $clog2(QUEUE_SIZE);

  logic [LOG_PHYS-1:0]     r_src1    [QUEUE_SIZE];
  logic [LOG_PHYS-1:0]     r_src2    [QUEUE_SIZE];
  logic [PAYLOAD_BITS-1:0] r_payload [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0]   r_rdy1, r_rdy2;
  logic [CNT_W-1:0]        r_count;

  logic [LOG_PHYS-1:0]     w_src1_nxt    [QUEUE_SIZE];
  logic [LOG_PHYS-1:0]     w_src2_nxt    [QUEUE_SIZE];
  logic [PAYLOAD_BITS-1:0] w_payload_nxt [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0]   w_rdy1_nxt, w_rdy2_nxt;
  logic [CNT_W-1:0]        w_cnt_after_issue;
  logic [IDX_W-1:0]        w_sel;
  logic                    w_issue_valid, w_issue_fire, w_enq_fire;
  logic                    w_enq_rdy1, w_enq_rdy2;

  // Tag 0 is hardwired ready, so it counts as a hit without any broadcast.
  function automatic logic f_wake_hit(input logic [LOG_PHYS-1:0]            tag,
                                      input logic [NUM_WAKEUP-1:0]          vld,
                                      input logic [NUM_WAKEUP*LOG_PHYS-1:0] regs);
    logic hit;
    hit = (tag == '0);
    for (int k = 0; k < NUM_WAKEUP; k++)
      hit = hit | (vld[k] && regs[k*LOG_PHYS +: LOG_PHYS] == tag);
    return hit;
  endfunction

  // Downward scan so the lowest-index (oldest) ready slot wins.
  always_comb begin
    w_issue_valid = 1'b0;
    w_sel         = '0;
    for (int i = QUEUE_SIZE - 1; i >= 0; i--) begin
      if (i < int'(r_count) && r_rdy1[i] && r_rdy2[i]) begin
        w_issue_valid = 1'b1;
        w_sel         = IDX_W'(i);
      end
    end
  end

  assign Enq_Ready_OUT     = (r_count < CNT_W'(QUEUE_SIZE));
  assign Issue_Valid_OUT   = w_issue_valid;
  assign Issue_Payload_OUT = w_issue_valid ? r_payload[w_sel] : '0;
  assign Count_OUT         = r_count;

  assign w_issue_fire      = w_issue_valid && Issue_Ready_IN;
  assign w_enq_fire        = Enq_Valid_IN && Enq_Ready_OUT;
  assign w_cnt_after_issue = r_count - {{(CNT_W-1){1'b0}}, w_issue_fire};
  assign w_enq_rdy1 = Enq_Src1Ready_IN | f_wake_hit(Enq_Src1_IN, Wakeup_Valid_IN, Wakeup_Reg_IN);
  assign w_enq_rdy2 = Enq_Src2Ready_IN | f_wake_hit(Enq_Src2_IN, Wakeup_Valid_IN, Wakeup_Reg_IN);

  // Next slot image: compact past the issued slot, apply wakeups in the post-shift
  // position, then drop the new entry into the first free slot.
  always_comb begin
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      automatic int j = (i < QUEUE_SIZE - 1) ? i + 1 : i;
      w_src1_nxt[i]    = r_src1[i];
      w_src2_nxt[i]    = r_src2[i];
      w_rdy1_nxt[i]    = r_rdy1[i];
      w_rdy2_nxt[i]    = r_rdy2[i];
      w_payload_nxt[i] = r_payload[i];
      if (w_issue_fire && i >= int'(w_sel)) begin
        w_src1_nxt[i]    = r_src1[j];
        w_src2_nxt[i]    = r_src2[j];
        w_rdy1_nxt[i]    = r_rdy1[j];
        w_rdy2_nxt[i]    = r_rdy2[j];
        w_payload_nxt[i] = r_payload[j];
      end
      w_rdy1_nxt[i] = w_rdy1_nxt[i] | f_wake_hit(w_src1_nxt[i], Wakeup_Valid_IN, Wakeup_Reg_IN);
      w_rdy2_nxt[i] = w_rdy2_nxt[i] | f_wake_hit(w_src2_nxt[i], Wakeup_Valid_IN, Wakeup_Reg_IN);
      if (w_enq_fire && i == int'(w_cnt_after_issue)) begin
        w_src1_nxt[i]    = Enq_Src1_IN;
        w_src2_nxt[i]    = Enq_Src2_IN;
        w_rdy1_nxt[i]    = w_enq_rdy1;
        w_rdy2_nxt[i]    = w_enq_rdy2;
        w_payload_nxt[i] = Enq_Payload_IN;
      end
    end
  end

  // Flush shares the reset path; RESET wins simply by being ORed in.
  always_ff @(posedge CLK) begin
    if (RESET || Flush_IN) begin
      r_count <= '0;
      r_rdy1  <= '0;
      r_rdy2  <= '0;
    end else begin
      r_count <= w_cnt_after_issue + {{(CNT_W-1){1'b0}}, w_enq_fire};
      r_rdy1  <= w_rdy1_nxt;
      r_rdy2  <= w_rdy2_nxt;
    end
  end

  // NOTE: tag/payload storage is deliberately not reset; slots at or above r_count are
  // never observed, and the payload output is gated to zero when nothing is selected.
  always_ff @(posedge CLK) begin
    r_src1    <= w_src1_nxt;
    r_src2    <= w_src2_nxt;
    r_payload <= w_payload_nxt;
  end

endmodule

// File: tb/tb_issue_queue_mw.sv
// Bench for issue_queue_mw: directed scenarios plus random traffic, every cycle compared
// against a queue-based model of the oldest-ready-first issue rules.
module tb_issue_queue_mw;

  localparam int QS = 16;
  localparam int LP = 6;
  localparam int PB = 128;
  localparam int NW = 2;

  logic            clk = 1'b0;
  logic            rst, flush, enq_valid, sr1, sr2, issue_ready;
  logic [LP-1:0]   s1, s2;
  logic [PB-1:0]   pay;
  logic [NW-1:0]   wake_v;
  logic [NW*LP-1:0] wake_r;
  logic            enq_ready_o, issue_valid_o;
  logic [PB-1:0]   issue_pay_o;
  logic [4:0]      count_o;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [LP-1:0] s1;
    bit            r1;
    logic [LP-1:0] s2;
    bit            r2;
    logic [PB-1:0] pay;
  } entry_t;
  entry_t mq[$];

  issue_queue_mw dut (
    .CLK(clk), .RESET(rst), .Flush_IN(flush),
    .Enq_Valid_IN(enq_valid), .Enq_Ready_OUT(enq_ready_o),
    .Enq_Src1_IN(s1), .Enq_Src1Ready_IN(sr1),
    .Enq_Src2_IN(s2), .Enq_Src2Ready_IN(sr2),
    .Enq_Payload_IN(pay),
    .Wakeup_Valid_IN(wake_v), .Wakeup_Reg_IN(wake_r),
    .Issue_Valid_OUT(issue_valid_o), .Issue_Ready_IN(issue_ready),
    .Issue_Payload_OUT(issue_pay_o), .Count_OUT(count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PB-1:0] got, input logic [PB-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit m_hit(input logic [LP-1:0] tag);
    if (tag == 0) return 1'b1;
    for (int k = 0; k < NW; k++)
      if (wake_v[k] && wake_r[k*LP +: LP] == tag) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_sel();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  task automatic check_outputs();
    int sel;
    sel = m_sel();
    check("count", PB'(count_o), PB'(mq.size()));
    check("enq_ready", PB'(enq_ready_o), PB'(mq.size() < QS));
    check("issue_valid", PB'(issue_valid_o), PB'(sel >= 0));
    check("issue_payload", issue_pay_o, (sel >= 0) ? mq[sel].pay : '0);
  endtask

  task automatic model_update();
    bit     enq_ok;
    int     sel;
    entry_t e;
    if (rst || flush) begin
      mq.delete();
      return;
    end
    enq_ok = enq_valid && (mq.size() < QS);
    sel    = m_sel();
    if (sel >= 0 && issue_ready) mq.delete(sel);
    for (int i = 0; i < mq.size(); i++) begin
      e = mq[i];
      if (m_hit(e.s1)) e.r1 = 1'b1;
      if (m_hit(e.s2)) e.r2 = 1'b1;
      mq[i] = e;
    end
    if (enq_ok) begin
      e.s1 = s1; e.r1 = sr1 || m_hit(s1);
      e.s2 = s2; e.r2 = sr2 || m_hit(s2);
      e.pay = pay;
      mq.push_back(e);
    end
  endtask

  // Inputs are set at the negedge; outputs are checked there, the model steps at posedge.
  task automatic cycle();
    #1 check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; flush = 0; enq_valid = 0; sr1 = 0; sr2 = 0; issue_ready = 0;
    s1 = '0; s2 = '0; pay = '0; wake_v = '0; wake_r = '0;
  endtask

  task automatic set_enq(input int t1, input int t2, input int p);
    enq_valid = 1; s1 = LP'(t1); s2 = LP'(t2); sr1 = 0; sr2 = 0; pay = PB'(p);
  endtask

  task automatic do_flush();
    idle(); flush = 1; cycle(); idle();
  endtask

  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    mq.delete();
    rst = 0;
    check("rst_count", PB'(count_o), '0);
    check("rst_enq_ready", PB'(enq_ready_o), PB'(1));
    check("rst_issue_valid", PB'(issue_valid_o), '0);
    check("rst_payload", issue_pay_o, '0);

    // Oldest-ready select with only the tag-0 entry ready.
    idle(); set_enq(5, 6, 1); cycle();
    idle(); set_enq(7, 0, 2); cycle();
    idle(); set_enq(0, 0, 3); cycle();
    idle();
    check("s1_count", PB'(count_o), PB'(3));
    check("s1_payload", issue_pay_o, PB'(3));
    issue_ready = 1; cycle(); idle();
    check("s1_count_after_issue", PB'(count_o), PB'(2));

    // Single-port wakeup latency.
    do_flush();
    set_enq(9, 0, 10); cycle();
    idle(); set_enq(9, 0, 11); cycle();
    idle(); wake_v = 2'b01; wake_r = {6'd0, 6'd9}; issue_ready = 1;
    #1 check("s2_valid_cycleN", PB'(issue_valid_o), '0);
    cycle();
    idle(); issue_ready = 1;
    check("s2_valid_N1", PB'(issue_valid_o), PB'(1));
    check("s2_payload_N1", issue_pay_o, PB'(10));
    cycle();
    check("s2_payload_N2", issue_pay_o, PB'(11));
    cycle(); idle();

    // Dual-port wakeup, then the same wakeups bypassing into a same-cycle enqueue.
    do_flush();
    set_enq(12, 13, 20); cycle();
    idle(); wake_v = 2'b11; wake_r = {6'd13, 6'd12}; cycle();
    idle();
    check("s3_dual_valid", PB'(issue_valid_o), PB'(1));
    check("s3_dual_payload", issue_pay_o, PB'(20));
    do_flush();
    set_enq(12, 13, 21); wake_v = 2'b11; wake_r = {6'd13, 6'd12}; cycle();
    idle();
    check("s3_bypass_payload", issue_pay_o, PB'(21));

    // Fill, drop when full, issue then refill; youngest drains last.
    do_flush();
    for (int i = 0; i < QS; i++) begin idle(); set_enq(0, 1, 100 + i); cycle(); end
    idle();
    check("s4_full_ready", PB'(enq_ready_o), '0);
    check("s4_full_count", PB'(count_o), PB'(16));
    set_enq(0, 0, 999); cycle();
    idle(); check("s4_drop_count", PB'(count_o), PB'(16));
    wake_v = 2'b01; wake_r = {6'd0, 6'd1}; cycle();
    idle(); issue_ready = 1; set_enq(0, 0, 500); cycle();
    idle(); check("s4_issue_at_full", PB'(count_o), PB'(15));
    issue_ready = 1; set_enq(0, 0, 501); cycle();
    idle(); check("s4_issue_enq_same", PB'(count_o), PB'(15));
    set_enq(0, 0, 502); cycle();
    idle();
    check("s4_refull", PB'(count_o), PB'(16));
    issue_ready = 1;
    for (int i = 0; i < QS - 1; i++) cycle();
    check("s4_youngest_last", issue_pay_o, PB'(502));
    cycle(); idle();

    // Out-of-order select and compaction preserving the shifted entry's state.
    do_flush();
    set_enq(30, 0, 40); cycle();
    idle(); set_enq(31, 0, 41); cycle();
    idle(); set_enq(0, 0, 42); cycle();
    idle(); set_enq(33, 34, 43); cycle();
    idle();
    check("s5_ooo_payload", issue_pay_o, PB'(42));
    issue_ready = 1; wake_v = 2'b01; wake_r = {6'd0, 6'd33}; cycle();
    idle(); check("s5_count", PB'(count_o), PB'(3));
    check("s5_no_issue_yet", PB'(issue_valid_o), '0);
    wake_v = 2'b01; wake_r = {6'd0, 6'd34}; cycle();
    idle(); check("s5_shifted_payload", issue_pay_o, PB'(43));

    // Flush beats enqueue/wakeup; RESET with flush gives the same empty state.
    do_flush();
    for (int i = 0; i < 10; i++) begin idle(); set_enq(1, 0, 60 + i); cycle(); end
    idle(); flush = 1; set_enq(0, 0, 77); wake_v = 2'b11; wake_r = {6'd1, 6'd1}; cycle();
    idle();
    check("s6_flush_count", PB'(count_o), '0);
    check("s6_flush_valid", PB'(issue_valid_o), '0);
    for (int i = 0; i < 5; i++) begin idle(); set_enq(0, 0, 80 + i); cycle(); end
    idle(); rst = 1; flush = 1; set_enq(0, 0, 90); issue_ready = 1; cycle();
    idle();
    check("s6_reset_count", PB'(count_o), '0);
    check("s6_reset_valid", PB'(issue_valid_o), '0);

    // Random traffic on a small tag space so wakeups hit often.
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst         = ($urandom % 300) == 0;
      flush       = ($urandom % 64) == 0;
      enq_valid   = ($urandom % 3) != 0;
      s1          = LP'($urandom_range(0, 7));
      s2          = LP'($urandom_range(0, 7));
      sr1         = ($urandom % 4) == 0;
      sr2         = ($urandom % 4) == 0;
      pay         = {$urandom, $urandom, $urandom, $urandom};
      wake_v      = NW'($urandom);
      wake_r      = {LP'($urandom_range(0, 7)), LP'($urandom_range(0, 7))};
      issue_ready = ($urandom % 4) != 0;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/issue_queue_mw.md
Name: issue_queue_mw

Overview:
Parametrised successor to the single-wakeup issue queue. Holds renamed instructions until both source operands are ready, then issues the oldest ready entry. Supports NUM_WAKEUP simultaneous wakeup broadcasts, a valid/ready handshake on enqueue and issue, and a flush. It sits between rename/dispatch and the execute stage.

Parameters:
NUM_PHYS_REGS, 64, number of physical registers; tag width LOG_PHYS = clog2(NUM_PHYS_REGS).
QUEUE_SIZE, 16, number of entries; must be at least 2.
NUM_WAKEUP, 2, number of wakeup broadcast ports per cycle; must be at least 1.
PAYLOAD_BITS, 128, opaque instruction payload carried with each entry.

Ports:
CLK  in  1  clock; all state updates on posedge.
RESET  in  1  synchronous, active-high reset.
Flush_IN  in  1  discard all entries.
Enq_Valid_IN  in  1  enqueue request.
Enq_Ready_OUT  out  1  queue can accept an entry this cycle.
Enq_Src1_IN  in  LOG_PHYS  source 1 tag.
Enq_Src1Ready_IN  in  1  source 1 already ready.
Enq_Src2_IN  in  LOG_PHYS  source 2 tag.
Enq_Src2Ready_IN  in  1  source 2 already ready.
Enq_Payload_IN  in  PAYLOAD_BITS  instruction payload.
Wakeup_Valid_IN  in  NUM_WAKEUP  per-port broadcast valid.
Wakeup_Reg_IN  in  NUM_WAKEUP*LOG_PHYS  per-port tag; port k occupies bits [k*LOG_PHYS +: LOG_PHYS].
Issue_Valid_OUT  out  1  a ready entry is presented.
Issue_Ready_IN  in  1  consumer accepts the presented entry.
Issue_Payload_OUT  out  PAYLOAD_BITS  payload of the selected entry.
Count_OUT  out  clog2(QUEUE_SIZE)+1  number of occupied entries.

Behaviour:
- Storage: compacting age-ordered array. Slot 0 is the oldest entry. Slots [0, count) are valid.
- Per entry: src1 tag, src1 ready, src2 tag, src2 ready, payload.
- Tag 0 is always ready. A source with tag 0 is stored as ready regardless of the SrcReady input.
- Reset (RESET=1 at posedge): count=0, all ready bits cleared. Outputs: Enq_Ready_OUT=1, Issue_Valid_OUT=0, Issue_Payload_OUT=0, Count_OUT=0.
- Enq_Ready_OUT = (count < QUEUE_SIZE). It comes from registered state only; a dequeue in the same cycle does not grant a slot.
- Enqueue fires when Enq_Valid_IN && Enq_Ready_OUT. The entry is written to slot count (after compaction, if an issue also fires).
- Select is combinational from registered state: the lowest-index valid slot with src1 ready && src2 ready.
  - Issue_Valid_OUT = 1 if such a slot exists.
  - Issue_Payload_OUT = that slot's payload, or 0 when none exists.
- Issue fires when Issue_Valid_OUT && Issue_Ready_IN.
  - Slots above the issued index shift down by one.
  - count decrements.
  - At most one issue per cycle.
- Wakeup, for each port k with Wakeup_Valid_IN[k]=1, for each valid slot and each source:
  - If the tag equals Wakeup_Reg_IN[k], the ready bit is set at the next posedge.
  - Matches on multiple ports are ORed.
  - Wakeups never clear a ready bit.
- Wakeup-to-issue latency: 1 cycle. A wakeup in cycle N affects select in cycle N+1, never cycle N.
- Wakeups apply to shifted entries in their post-shift slot.
- Wakeups also apply to the entry being enqueued in the same cycle: its ready bit = SrcReady_IN || tag==0 || any matching wakeup port.
- Simultaneous enqueue and issue: count stays unchanged. The new entry lands in slot count-1 after the shift.
- Flush_IN=1: same effect as reset on the next posedge. Flush overrides enqueue, issue and wakeup in that cycle. Issue_Valid_OUT may still be 1 during the flush cycle, but the consumer must ignore it.
- RESET takes priority over Flush_IN. RESET in the middle of streaming traffic drops all state, and no partial entry survives.
- Enqueue while full: ignored, and no state changes.
- Issue_Ready_IN while Issue_Valid_OUT=0: no effect.
- Wakeups for tags absent from the queue: no effect.

Test Plan:
- Reset, then enqueue 3 entries with src tags (5,6), (7,0), (0,0), all SrcReady=0. Required: Count_OUT=3; the first presented payload is entry 3 (slot 2); with Issue_Ready_IN=1 it issues next cycle and Count_OUT=2.
- With 2 entries waiting on tag 9, assert Wakeup_Valid=2'b01, tag 9, in cycle N. Required: Issue_Valid_OUT=0 in cycle N, =1 in cycle N+1 showing the older entry; the younger entry issues in cycle N+2.
- Dual-port wakeup: one entry with src (12,13); port0=12 and port1=13 in the same cycle. Required: issue valid in the next cycle. Also cover the enqueue-bypass case: enqueue src (12,13) in the same cycle as those wakeups, then the entry is ready in the next cycle.
- Fill to QUEUE_SIZE=16. Required: Enq_Ready_OUT=0 and Count_OUT=16; a further Enq_Valid is dropped. Then issue and enqueue in the same cycle: Count_OUT returns to 16 and the new entry is the youngest.
- Out-of-order select: slots 0..3 with only slot 2 ready. Required: slot 2 issues, and old slot 3 moves to slot 2 with its state preserved.
- Flush with 10 entries alongside a simultaneous enqueue and wakeup: Count_OUT=0 and Issue_Valid_OUT=0 next cycle. Also cover RESET held together with Flush: same result.
